// File: rtl/dot_vector_loader.sv
// dot_vector_loader: gathers 32 operand bytes into A/B vectors, starts the dot engine, waits at least MIN_LAT cycles for done, then hands the 16-bit result downstream.
// Ports: clk/rst_n (async active-low reset); s_valid/s_data/s_ready byte input;
// eng_a/eng_b/eng_start/eng_c/eng_done engine side; m_valid/m_data/m_ready result output; busy status.
module dot_vector_loader #(
  parameter int MIN_LAT = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [7:0]  eng_a [0:15],
  output logic [7:0]  eng_b [0:15],
  output logic        eng_start,
  input  logic [15:0] eng_c,
  input  logic        eng_done,
  output logic        m_valid,
  output logic [15:0] m_data,
  input  logic        m_ready,
  output logic        busy
);
  localparam logic [1:0] LOAD = 2'd0, START = 2'd1, WAIT = 2'd2, OUT = 2'd3;
  localparam int CW = $clog2(MIN_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MIN_LAT);
  logic [1:0]    r_state;
  logic [5:0]    r_k;
  logic [CW-1:0] r_cnt;
  logic          w_take;
  logic          w_fire;
  logic [1:0]    w_next;
  assign w_take    = r_state == LOAD && s_valid;
  // r_cnt equals the current cycle index since eng_start, saturated at MIN_LAT,
  // so a done seen before MIN_LAT (left over from the last operation) is ignored.
  assign w_fire    = r_state == WAIT && eng_done && r_cnt == LAT;
  assign s_ready   = r_state == LOAD;
  assign eng_start = r_state == START;
  assign m_valid   = r_state == OUT;
  assign busy      = !(r_state == LOAD && r_k == 6'd0);
  always_comb begin
    w_next = r_state == LOAD  ? ((w_take && r_k == 6'd31) ? START : LOAD) :
             r_state == START ? WAIT :
             r_state == WAIT  ? (w_fire ? OUT : WAIT) :
                                (m_ready ? LOAD : OUT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_k     <= '0;
      r_cnt   <= '0;
      m_data  <= '0;
      for (int i = 0; i < 16; i++) begin
        eng_a[i] <= '0;
        eng_b[i] <= '0;
      end
    end else begin
      if (w_take) begin
        if (r_k[4]) eng_b[r_k[3:0]] <= s_data;
        else eng_a[r_k[3:0]] <= s_data;
        r_k <= r_k == 6'd31 ? 6'd0 : r_k + 6'd1;
      end
      if (w_fire) m_data <= eng_c;
      r_cnt   <= r_state == START ? CW'(1) : r_state != WAIT ? '0 : r_cnt + CW'(r_cnt != LAT);
      r_state <= w_next;
    end
  end
endmodule

// File: tb/tb_dot_vector_loader.sv
// tb_dot_vector_loader: directed and randomized operations checked against a dot-product reference model.
module tb_dot_vector_loader;
  localparam int LAT = 17;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [7:0]  eng_a [0:15];
  logic [7:0]  eng_b [0:15];
  logic        eng_start;
  logic [15:0] eng_c;
  logic        eng_done;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;
  logic        busy;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  va [16];
  logic [7:0]  vb [16];

  dot_vector_loader #(.MIN_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start), .eng_c(eng_c), .eng_done(eng_done),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dot();
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s += 32'(va[i]) * 32'(vb[i]);
    return s[15:0];
  endfunction

  function automatic bit vec_ok();
    for (int i = 0; i < 16; i++) if (eng_a[i] !== va[i] || eng_b[i] !== vb[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit vec_zero();
    for (int i = 0; i < 16; i++) if (eng_a[i] !== 8'd0 || eng_b[i] !== 8'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic randomize_vecs();
    for (int i = 0; i < 16; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
    end
  endtask

  task automatic send(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        s_valid = 1'b0;
        s_data  = 8'hEE;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = i < 16 ? va[i] : vb[i-16];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  // stall: number of OUT cycles with m_ready low (>=1); d: cycle at which a fresh done appears
  task automatic op(input bit gap, input int stall, input bit stale, input int d);
    logic [15:0] exp;
    int cap, want;
    exp = dot();
    send(32, gap);
    check("start_pulse", eng_start, 1);
    check("start_sready", s_ready, 0);
    check("vectors_loaded", vec_ok(), 1);
    s_valid  = 1'b1;
    s_data   = 8'h5A;
    eng_done = stale;
    eng_c    = 16'hBAD0;
    want = stale ? LAT : (d > LAT ? d : LAT);
    cap = -1;
    for (int n = 1; n < 300 && cap < 0; n++) begin
      @(posedge clk); #1;
      if (m_valid) cap = n - 1;
      else begin
        if (n == 1) begin
          check("start_one_cycle", eng_start, 0);
          check("wait_busy", busy, 1);
          check("wait_sready", s_ready, 0);
        end
        eng_done = stale || n >= d;
        eng_c    = (stale ? n >= LAT : n >= d) ? exp : (16'hBAD0 ^ 16'(n));
      end
    end
    check("capture_cycle", cap, want);
    check("m_data", m_data, exp);
    check("vectors_held", vec_ok(), 1);
    check("out_sready", s_ready, 0);
    for (int i = 1; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", m_valid, 1);
      check("stall_data", m_data, exp);
      check("stall_sready", s_ready, 0);
    end
    m_ready = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("out_done", m_valid, 0);
    check("load_ready", s_ready, 1);
    check("idle_busy", busy, 0);
    m_ready  = 1'b0;
    eng_done = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; eng_done = 1'b0; eng_c = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_sready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", eng_start, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_vectors", vec_zero(), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_sready", s_ready, 1);
    for (int i = 0; i < 16; i++) begin
      va[i] = 8'(i);
      vb[i] = 8'd1;
    end
    check("model_basic", 32'(dot()), 32'd120);
    op(1'b0, 1, 1'b0, 20);
    for (int i = 0; i < 16; i++) begin
      va[i] = 8'hFF;
      vb[i] = 8'hFF;
    end
    check("model_wrap", 32'(dot()), 32'd57360);
    op(1'b0, 2, 1'b0, 17);
    randomize_vecs();
    op(1'b0, 1, 1'b1, 0);
    randomize_vecs();
    op(1'b0, 5, 1'b0, 25);
    randomize_vecs();
    op(1'b1, 1, 1'b0, 5);
    randomize_vecs();
    send(10, 1'b0);
    check("partial_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_sready", s_ready, 1);
    check("async_rst_mdata", m_data, 0);
    check("async_rst_mvalid", m_valid, 0);
    check("async_rst_vectors", vec_zero(), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rerst_sready", s_ready, 1);
    randomize_vecs();
    op(1'b0, 1, 1'b0, int'($urandom_range(1, 30)));
    for (int r = 0; r < 4; r++) begin
      randomize_vecs();
      op(1'(($urandom_range(0, 1))), int'($urandom_range(1, 3)), 1'(($urandom_range(0, 1))), int'($urandom_range(1, 40)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dot_vector_loader.md
DOT_VECTOR_LOADER -- requirements
Module: dot_vector_loader

Interface
REQ-001 SHALL have parameter MIN_LAT, default 17: minimum cycles from the eng_start cycle (cycle 0) before eng_done is honoured.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port s_valid, input, 1: upstream byte valid.
REQ-005 SHALL have port s_data, input, 8: upstream operand byte.
REQ-006 SHALL have port s_ready, output, 1: loader accepts a byte.
REQ-007 SHALL have port eng_a, output, 8 x [0:15]: operand vector A to the dot engine.
REQ-008 SHALL have port eng_b, output, 8 x [0:15]: operand vector B to the dot engine.
REQ-009 SHALL have port eng_start, output, 1: one-cycle start pulse to the dot engine.
REQ-010 SHALL have port eng_c, input, 16: engine accumulated result.
REQ-011 SHALL have port eng_done, input, 1: engine completion; may stay high between operations.
REQ-012 SHALL have port m_valid, output, 1: result valid downstream.
REQ-013 SHALL have port m_data, output, 16: captured dot product.
REQ-014 SHALL have port m_ready, input, 1: downstream accepts the result.
REQ-015 SHALL have port busy, output, 1: high in every state except LOAD with byte count 0.

Function
REQ-016 SHALL implement FSM states LOAD, START, WAIT, OUT; after reset the state SHALL be LOAD.
REQ-017 SHALL, in LOAD, drive s_ready=1; a byte transfers on an edge with s_valid&&s_ready; s_ready SHALL be 0 in all other states.
REQ-018 SHALL keep a 6-bit byte count k (0..31): byte k<16 writes eng_a[k]; byte k>=16 writes eng_b[k-16].
REQ-019 SHALL, on the transfer of byte 31, clear k to 0 and go to START on the next cycle.
REQ-020 SHALL drive eng_start=1 for exactly one cycle (START), then enter WAIT; eng_start SHALL be 0 in all other states.
REQ-021 SHALL hold eng_a and eng_b constant from the START cycle until the next LOAD transfer.
REQ-022 SHALL count WAIT cycles with the eng_start cycle as cycle 0; the counter SHALL saturate at MIN_LAT and not wrap.
REQ-023 SHALL complete in the first cycle n>=MIN_LAT with eng_done=1, capture eng_c into m_data on that edge, and enter OUT.
REQ-024 SHALL ignore eng_done=1 before cycle MIN_LAT (stale done from a previous operation).
REQ-025 SHALL stay in WAIT indefinitely while eng_done=0; there is no timeout.
REQ-026 SHALL drive m_valid=1 exactly while in OUT, with m_data stable; on m_valid&&m_ready it returns to LOAD on the next cycle.
REQ-027 SHALL make m_data 16 bits wide and pass it through unmodified (no widening, no saturation).
REQ-028 SHALL make OUT->LOAD->first byte accepted take no fewer than 1 cycle; a byte offered while s_ready=0 is not consumed.
REQ-029 SHALL drive busy combinationally from state and k.

Reset
REQ-030 SHALL, on rst_n low at any time, asynchronously force: state=LOAD, k=0, WAIT counter=0, all eng_a/eng_b elements=0, eng_start=0, m_valid=0, m_data=0.
REQ-031 SHALL discard any partial load or in-flight operation on reset; the next operation restarts from byte 0.
REQ-032 SHALL drive s_ready=1 from the first cycle after rst_n rises.

Verification
REQ-033 SHALL cover basic: A bytes 0..15, B bytes all 1, s_valid held high -> eng_start pulses the cycle after byte 31; engine returns 120 -> m_data=0x0078, m_valid until m_ready.
REQ-034 SHALL cover wrap: A and B all 0xFF -> m_data=57360 (0xE010).
REQ-035 SHALL cover stale done: eng_done held high from the previous operation -> no capture before cycle 17 after eng_start; capture at cycle 17 with the new eng_c.
REQ-036 SHALL cover backpressure: m_ready low for 5 cycles in OUT -> m_valid and m_data held stable and s_ready=0 throughout; completes on the 6th cycle.
REQ-037 SHALL cover gapped input: s_valid toggled every other cycle -> all 32 bytes land in the correct eng_a/eng_b slots, and no byte is consumed outside LOAD.
REQ-038 SHALL cover reset after 10 bytes: all outputs return to reset values; the following 32 bytes yield a correct result from byte 0.
